// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline widths, memory-stage FSM states and EX/MEM control bundle
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, FAULT} mem_state_e;
  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [REG_W-1:0] dst_reg;
  } mem_ctl_t;
endpackage

// File: rtl/dmem_handshake.sv
// dmem_handshake: req/ack FSM with bounded wait counter, stall and sticky fault generation
module dmem_handshake #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hlt,
  input  logic memop,
  input  logic dm_ack,
  output logic dm_req,
  output logic mem_stall,
  output logic mem_fault
);
  import cpu_pkg::*;
  mem_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    dm_req    = memop && state_q != FAULT;
    mem_stall = (dm_req && !dm_ack) || state_q == FAULT;
    mem_fault = state_q == FAULT;
    // counter holds the number of unacked request cycles seen so far
    cnt_d     = (dm_req && !dm_ack) ? cnt_q + 8'd1 : 8'd0;
    state_d   = state_q == IDLE ? ((memop && !dm_ack) ? WAIT : IDLE) :
                state_q == WAIT ? (dm_ack ? IDLE : (cnt_q == 8'(TIMEOUT)) ? FAULT : WAIT) :
                FAULT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (!hlt) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline latches around the data-memory handshake
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [REG_W-1:0]  ex_dst_reg,
  output logic              mem_stall,
  output logic [DATA_W-1:0] MEM_alu_result,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_dst_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_fault
);
  import cpu_pkg::*;
  mem_ctl_t          m_ctl_q, m_ctl_d;
  logic [DATA_W-1:0] m_alu_q, m_st_q, wb_data_q, wb_data_d;
  logic              wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, memop;
  logic [REG_W-1:0]  wb_dst_q, wb_dst_d;
  always_comb begin
    m_ctl_d    = ex_valid ? mem_ctl_t'{valid: 1'b1, reg_write: ex_reg_write, mem_read: ex_mem_read,
                                       mem_write: ex_mem_write, dst_reg: ex_dst_reg} : '0;
    wb_valid_d = !mem_stall && m_ctl_q.valid;
    wb_rw_d    = !mem_stall && m_ctl_q.reg_write;
    wb_dst_d   = mem_stall ? '0 : m_ctl_q.dst_reg;
    wb_data_d  = mem_stall ? '0 : m_ctl_q.mem_read ? dm_rdata : m_alu_q;
  end
  assign memop          = m_ctl_q.valid && (m_ctl_q.mem_read || m_ctl_q.mem_write);
  assign dm_we          = m_ctl_q.mem_write && !m_ctl_q.mem_read;
  assign dm_addr        = m_alu_q;
  assign dm_wdata       = m_st_q;
  assign MEM_alu_result = m_alu_q;
  assign wb_valid       = wb_valid_q;
  assign wb_reg_write   = wb_rw_q;
  assign wb_dst_reg     = wb_dst_q;
  assign wb_data        = wb_data_q;
  dmem_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
    .clk       (clk),
    .rst_n     (rst_n),
    .hlt       (hlt),
    .memop     (memop),
    .dm_ack    (dm_ack),
    .dm_req    (dm_req),
    .mem_stall (mem_stall),
    .mem_fault (mem_fault)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctl_q    <= '0;
      m_alu_q    <= '0;
      m_st_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_dst_q   <= '0;
      wb_data_q  <= '0;
    end else if (!hlt) begin
      if (!mem_stall) begin
        m_ctl_q <= m_ctl_d;
        m_alu_q <= ex_alu_result;
        m_st_q  <= ex_store_data;
      end
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_dst_q   <= wb_dst_d;
      wb_data_q  <= wb_data_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven pipeline vectors with a WB scoreboard, plus handshake corner sequences
module tb_mem_stage;
  logic clk = 1'b0, rst_n, hlt;
  logic ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [15:0] ex_alu_result, ex_store_data, MEM_alu_result, dm_addr, dm_wdata, dm_rdata, wb_data;
  logic [3:0] ex_dst_reg, wb_dst_reg;
  logic mem_stall, dm_req, dm_we, dm_ack, wb_valid, wb_reg_write, mem_fault;
  int n_cmp = 0, n_bad = 0;

  mem_stage #(.DATA_W(16), .REG_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .hlt(hlt), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_dst_reg(ex_dst_reg),
    .mem_stall(mem_stall), .MEM_alu_result(MEM_alu_result),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_dst_reg(wb_dst_reg), .wb_data(wb_data),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic valid, rd, wr, rw;
    logic [3:0] dst;
    logic [15:0] alu, st, exp;
    int lat;
  } vec_t;
  typedef struct {
    logic [3:0] dst;
    logic rw;
    logic [15:0] data;
  } wb_t;

  wb_t sb[$];
  wb_t e;
  logic [15:0] mem [256];
  logic init, auto_ack, man_ack, mon_en;
  int lat, req_cnt, prev_lat;
  vec_t v [11];
  vec_t bub;

  function automatic logic [15:0] memv(input logic [7:0] a);
    return (a == 8'h40) ? 16'hBEEF : (16'hA5A5 ^ {a, ~a});
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // memory responder: auto mode acks after lat unacked request cycles
  always_comb begin
    dm_ack   = auto_ack ? (dm_req && req_cnt >= lat) : man_ack;
    dm_rdata = mem[dm_addr[7:0]];
  end

  always @(posedge clk) begin
    req_cnt <= (dm_req && !dm_ack) ? req_cnt + 1 : 0;
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= memv(8'(i));
    end else if (dm_req && dm_ack && dm_we) begin
      mem[dm_addr[7:0]] <= dm_wdata;
    end
  end

  always @(negedge clk) begin
    if (mon_en && wb_valid) begin
      if (sb.size() == 0) begin
        chk("sb_extra_wb", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_dst", 32'(wb_dst_reg), 32'(e.dst));
        chk("wb_rw", 32'(wb_reg_write), 32'(e.rw));
        chk("wb_data", 32'(wb_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vl, input logic rd, input logic wr, input logic rw,
                       input logic [3:0] dst, input logic [15:0] alu, input logic [15:0] st);
    ex_valid = vl; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
    ex_dst_reg = dst; ex_alu_result = alu; ex_store_data = st;
  endtask

  task automatic issue(input vec_t x);
    int st = 0;
    drive(x.valid, x.rd, x.wr, x.rw, x.dst, x.alu, x.st);
    if (x.valid) sb.push_back(wb_t'{x.dst, x.rw, x.exp});
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (!mem_stall) break;
      st++;
    end
    tick();
    chk("stall_cycles", 32'(st), 32'(prev_lat));
    chk("mem_alu", 32'(MEM_alu_result), 32'(x.alu));
    chk("dm_req", 32'(dm_req), 32'(x.valid && (x.rd || x.wr)));
    if (x.valid && (x.rd || x.wr)) chk("dm_we", 32'(dm_we), 32'(x.wr && !x.rd));
    lat = x.lat;
    prev_lat = (x.valid && (x.rd || x.wr)) ? x.lat : 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hlt = 1'b0; man_ack = 1'b0;
    drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //            valid rd   wr   rw   dst    alu       st        exp          lat
    v[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  16'h1234, 16'h0000, 16'h1234,    0};
    v[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  16'h0040, 16'h0000, 16'hBEEF,    0};
    v[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd6,  16'h0044, 16'h0000, 16'h0000,    0};
    v[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd7,  16'h0020, 16'h5A5A, 16'h0020,    0};
    v[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd9,  16'h0020, 16'h0000, 16'h5A5A,    0};
    v[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd2,  16'h0040, 16'hFFFF, 16'hBEEF,    0};
    v[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4,  16'h0041, 16'h0000, memv(8'h41), 2};
    v[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd8,  16'h0030, 16'h1111, 16'h0030,    1};
    v[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd10, 16'h0030, 16'h0000, 16'h1111,    0};
    v[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 16'hFFFF, 16'h0000, 16'hFFFF,    0};
    v[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1,  16'h0040, 16'h0000, 16'hBEEF,    0};
    bub   = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 16'h0000, 16'h0000,    0};
    rst_n = 1'b0; hlt = 1'b0; init = 1'b1; auto_ack = 1'b1; man_ack = 1'b0; mon_en = 1'b0;
    lat = 0; prev_lat = 0;
    drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_mem_alu", 32'(MEM_alu_result), 32'd0);
    init = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    mon_en = 1'b1;
    for (int i = 0; i < 11; i++) issue(v[i]);
    issue(bub);
    issue(bub);
    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    auto_ack = 1'b0;

    // three-wait store: outputs stable, WB bubbles, then completion
    drive(1, 0, 1, 0, 4'd11, 16'h0010, 16'h00AA);
    tick();
    drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("st3_stall", 32'(mem_stall), 32'd1);
      chk("st3_addr", 32'(dm_addr), 32'h0010);
      chk("st3_wdata", 32'(dm_wdata), 32'h00AA);
      chk("st3_we", 32'(dm_we), 32'd1);
      tick();
      chk("st3_wb_bubble", 32'(wb_valid), 32'd0);
    end
    man_ack = 1'b1;
    @(negedge clk);
    chk("st3_ack_nostall", 32'(mem_stall), 32'd0);
    tick();
    man_ack = 1'b0;
    chk("st3_wb_valid", 32'(wb_valid), 32'd1);
    chk("st3_wb_data", 32'(wb_data), 32'h0010);
    chk("st3_wb_rw", 32'(wb_reg_write), 32'd0);

    // hlt during WAIT: ack while halted is lost, re-ack completes the load
    drive(1, 1, 0, 1, 4'd6, 16'h0041, 16'd0);
    tick();
    drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
    tick();
    hlt = 1'b1;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("hlt_mem_alu", 32'(MEM_alu_result), 32'h0041);
    chk("hlt_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    hlt = 1'b0;
    chk("hlt_mem_alu2", 32'(MEM_alu_result), 32'h0041);
    chk("hlt_dm_req", 32'(dm_req), 32'd1);
    @(negedge clk);
    chk("hlt_ack_lost", 32'(mem_stall), 32'd1);
    tick();
    man_ack = 1'b1;
    @(negedge clk);
    chk("hlt_reack_nostall", 32'(mem_stall), 32'd0);
    tick();
    man_ack = 1'b0;
    chk("hlt_wb_valid2", 32'(wb_valid), 32'd1);
    chk("hlt_wb_data", 32'(wb_data), 32'(memv(8'h41)));
    chk("hlt_wb_dst", 32'(wb_dst_reg), 32'd6);

    // timeout with no ack: fault 16 cycles after req rises
    drive(1, 1, 0, 1, 4'd2, 16'h0050, 16'd0);
    tick();
    drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
    chk("to_req_rise", 32'(dm_req), 32'd1);
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk("to_no_early_fault", 32'(mem_fault), 32'd0);
    end
    tick();
    chk("to_fault", 32'(mem_fault), 32'd1);
    chk("to_req_drop", 32'(dm_req), 32'd0);
    chk("to_stall", 32'(mem_stall), 32'd1);
    repeat (3) tick();
    chk("to_stall_sticky", 32'(mem_stall), 32'd1);
    chk("to_fault_sticky", 32'(mem_fault), 32'd1);

    // ack on the timeout edge wins
    do_reset();
    chk("fault_cleared", 32'(mem_fault), 32'd0);
    drive(1, 1, 0, 1, 4'd12, 16'h0050, 16'd0);
    tick();
    drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
    repeat (15) tick();
    man_ack = 1'b1;
    @(negedge clk);
    chk("aw_nostall", 32'(mem_stall), 32'd0);
    tick();
    man_ack = 1'b0;
    chk("aw_no_fault", 32'(mem_fault), 32'd0);
    chk("aw_wb_valid", 32'(wb_valid), 32'd1);
    chk("aw_wb_data", 32'(wb_data), 32'(memv(8'h50)));

    // hlt freezes the wait counter: fault timing shifts by the halted cycles
    do_reset();
    drive(1, 1, 0, 1, 4'd13, 16'h0052, 16'd0);
    tick();
    drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
    tick();
    hlt = 1'b1;
    repeat (20) tick();
    hlt = 1'b0;
    chk("hc_no_fault_in_hlt", 32'(mem_fault), 32'd0);
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk("hc_no_early_fault", 32'(mem_fault), 32'd0);
    end
    tick();
    chk("hc_fault", 32'(mem_fault), 32'd1);

    // async reset in the second wait cycle
    do_reset();
    drive(1, 1, 0, 1, 4'd14, 16'h0060, 16'd0);
    tick();
    drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_dm_req", 32'(dm_req), 32'd0);
    chk("ar_stall", 32'(mem_stall), 32'd0);
    chk("ar_wb_valid", 32'(wb_valid), 32'd0);
    chk("ar_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("ar_wb_dst", 32'(wb_dst_reg), 32'd0);
    chk("ar_wb_data", 32'(wb_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("stray_ack_wb", 32'(wb_valid), 32'd0);
    chk("stray_ack_stall", 32'(mem_stall), 32'd0);
    drive(1, 1, 0, 1, 4'd1, 16'h0040, 16'd0);
    tick();
    drive(0, 0, 0, 0, 4'd0, 16'd0, 16'd0);
    man_ack = 1'b1;
    @(negedge clk);
    chk("ar_idle_nostall", 32'(mem_stall), 32'd0);
    tick();
    man_ack = 1'b0;
    chk("ar_load_data", 32'(wb_data), 32'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 16-bit five-stage pipeline, directly downstream of the execute stage. Latches execute-stage results into the EX/MEM register, performs data-memory loads and stores over a req/ack handshake with a bounded wait, stalls upstream while an access is outstanding, and drives the MEM/WB register. It also supplies the registered ALU result back to execute for MEM-to-EX forwarding.

## Interface
- `DATA_W`, 16, datapath and address width
- `REG_W`, 4, destination register index width
- `TIMEOUT`, 15, maximum stall cycles before fault; legal range 1..255
- `clk` in 1: pipeline clock
- `rst_n` in 1: reset, asynchronous, active-low
- `hlt` in 1: freeze all stage state; `dm_req` is unaffected
- `ex_valid` in 1: execute stage holds a real instruction
- `ex_alu_result` in DATA_W: ALU result or JAL link value; also the memory address
- `ex_store_data` in DATA_W: forwarded store operand
- `ex_mem_read` in 1: load
- `ex_mem_write` in 1: store
- `ex_reg_write` in 1: writeback enable, after ADDZ gating
- `ex_dst_reg` in REG_W: destination register
- `mem_stall` out 1: hold IF, ID and EX this cycle
- `MEM_alu_result` out DATA_W: EX/MEM ALU result, used for forwarding
- `dm_req` out 1: memory request
- `dm_we` out 1: 1 = write
- `dm_addr` out DATA_W: access address
- `dm_wdata` out DATA_W: store data
- `dm_rdata` in DATA_W: load data, valid when `dm_ack` = 1
- `dm_ack` in 1: access complete this cycle
- `wb_valid`, `wb_reg_write` out 1: MEM/WB control
- `wb_dst_reg` out REG_W: MEM/WB destination
- `wb_data` out DATA_W: writeback value; feeds `WB_reg_write_data`
- `mem_fault` out 1: sticky timeout flag

## Operation
**EX/MEM latch (m_\*)**
- Loads `ex_*` on each edge where `!hlt && !mem_stall`.
- If `ex_valid` = 0, loads a bubble: valid, reg_write, read and write all 0.
- Asserting both `ex_mem_read` and `ex_mem_write` is illegal. Treat it as a load.

**Access signals**
- memop = `m_valid & (m_mem_read | m_mem_write)`.
- `dm_req` = memop & state≠FAULT, combinational.
- `dm_addr` = `m_alu_result`. `dm_wdata` = `m_store_data`. `dm_we` = `m_mem_write & ~m_mem_read`.

**FSM**
- IDLE: memop & !dm_ack goes to WAIT. Otherwise stay.
- WAIT: dm_ack goes to IDLE. The wait counter reaching TIMEOUT goes to FAULT.
- FAULT: terminal until reset.

**Stall and wait counter**
- `mem_stall` = (dm_req & ~dm_ack) | state==FAULT.
- Zero-wait memory (ack in the same cycle as req) never stalls.
- The wait counter clears in IDLE and increments each WAIT cycle without ack.
- In FAULT, `mem_fault` = 1, `dm_req` = 0, and `mem_stall` = 1 permanently.

**MEM/WB latch**
- Updates on each edge where `!hlt`.
- If `mem_stall`, it loads a bubble.
- Otherwise it copies m_valid, m_reg_write and m_dst_reg.
- `wb_data` gets `dm_rdata` for a load, else `m_alu_result`.

## Timing
- All outputs reset to 0 and the FSM resets to IDLE. `dm_req` drops immediately on reset, including mid-access.
- Latency: one cycle EX to MEM, one cycle MEM to WB.
- A load with ack after k wait cycles stalls k cycles. `wb_data` is valid on the edge after ack.
- `dm_addr`, `dm_wdata` and `dm_we` hold stable while `dm_req` is high without ack.
- `dm_ack` while `dm_req` = 0 is ignored.
- `hlt` during WAIT freezes the FSM, counter and both latches. An ack arriving then is lost; memory must re-ack after `hlt` falls.
- Fault fires on the edge where the counter equals TIMEOUT with no ack, i.e. TIMEOUT+1 cycles after req rises.
- An ack arriving on that same edge wins: no fault is raised.

## Structure
- Shared package `cpu_pkg`: `DATA_W`, `REG_W`, the FSM state enum (IDLE, WAIT, FAULT) and the `mem_ctl_t` struct {valid, reg_write, mem_read, mem_write, dst_reg}.
- One sub-module, `dmem_handshake`: FSM, wait counter, `dm_req`, `mem_stall`, `mem_fault`.
- The latches stay in `mem_stage`.

## Test plan
- ALU pass-through: `ex_alu_result`=0x1234, reg_write=1, dst=3 → `MEM_alu_result`=0x1234 next cycle; `wb_data`=0x1234, dst=3 a cycle later; no stall.
- Zero-wait load: addr 0x0040, ack in the same cycle with rdata=0xBEEF → no stall, `wb_data`=0xBEEF.
- 3-wait store: addr 0x0010, data 0x00AA → `mem_stall` high 3 cycles; addr and data stable throughout; WB bubbles for 3 cycles; `dm_we`=1.
- Timeout: load with no ack and TIMEOUT=15 → `mem_fault` rises 16 cycles after req; `dm_req` falls; `mem_stall` stays 1.
- Reset mid-WAIT: assert `rst_n`=0 during the 2nd wait cycle → `dm_req`, `mem_stall` and all WB outputs go 0 asynchronously; FSM returns to IDLE.
- hlt during WAIT: 2 cycles of `hlt` → counter and latches unchanged; ack after `hlt` falls completes the load normally.
